// File: rtl/lcd_tile_fill_engine.sv
// Tile-map fill engine: CPU programs a rectangle and tile byte, engine writes the tiles as bus master.
// Optional build macro LCD_FILL_IRQ_EN adds the irq output and the CTRL bit3 interrupt enable.
module lcd_tile_fill_engine #(
    parameter int unsigned MAP_COLS = 60,
    parameter int unsigned MAP_ROWS = 34
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_select,
    input  logic [3:0]  cfg_wstrb,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_data_i,
    output logic        cfg_ready,
    output logic [31:0] cfg_data_o,
    output logic        mem_select,
    output logic [3:0]  mem_wstrb,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_data_o,
    input  logic        mem_ready,
`ifdef LCD_FILL_IRQ_EN
    output logic        irq,
`endif
    output logic        busy
);

    localparam logic [6:0]  COLS7  = 7'(MAP_COLS);
    localparam logic [6:0]  ROWS7  = 7'(MAP_ROWS);
    localparam logic [11:0] COLS12 = 12'(MAP_COLS);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_NEXT} state_t;

    state_t      state_q, state_d;
    logic        cfg_ready_q, cfg_ready_d;
    logic [31:0] cfg_data_q, cfg_data_d;
    logic        done_q, done_d, abort_q, abort_d, irq_en_q, irq_en_d;
    logic [5:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
    logic [7:0]  value_q, value_d;
    logic [6:0]  xe_q, xe_d, ye_q, ye_d;
    logic [5:0]  x_q, x_d, y_q, y_d;
    logic [11:0] offset_q, offset_d;
    logic        mem_sel_q, mem_sel_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;

    logic        is_busy, rd, wr, ctrl_wr, start, abort_set, enter_write;
    logic [6:0]  xsum, ysum, x_inc, y_inc;
    logic        unused_bits;

`ifdef LCD_FILL_IRQ_EN
    assign unused_bits = ^{cfg_data_i[31:30], cfg_data_i[23:22], cfg_data_i[15:14], cfg_data_i[7:6]};
`else
    assign unused_bits = ^{cfg_data_i[31:30], cfg_data_i[23:22], cfg_data_i[15:14], cfg_data_i[7:6],
                           cfg_data_i[3], irq_en_q};
`endif

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        abort_d     = abort_q;
        irq_en_d    = irq_en_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        w_d         = w_q;
        h_d         = h_q;
        value_d     = value_q;
        xe_d        = xe_q;
        ye_d        = ye_q;
        x_d         = x_q;
        y_d         = y_q;
        offset_d    = offset_q;
        mem_sel_d   = mem_sel_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        enter_write = 1'b0;

        is_busy     = (state_q != S_IDLE);
        cfg_ready_d = cfg_select & ~cfg_ready_q;
        rd          = cfg_select & ~cfg_ready_q & (cfg_wstrb == 4'b0000);
        wr          = cfg_select & cfg_ready_q & (cfg_wstrb != 4'b0000);
        ctrl_wr     = wr & (cfg_addr == 4'h0) & cfg_wstrb[0];
        start       = ctrl_wr & cfg_data_i[0] & ~cfg_data_i[2] & ~is_busy;
        abort_set   = ctrl_wr & cfg_data_i[2] & is_busy;

        cfg_data_d = '0;
        if (rd) begin
            case (cfg_addr)
                4'h0:    cfg_data_d = {28'b0, irq_en_q, abort_q, done_q, is_busy};
                4'h4:    cfg_data_d = {2'b0, h_q, 2'b0, w_q, 2'b0, y0_q, 2'b0, x0_q};
                4'h8:    cfg_data_d = {24'b0, value_q};
                default: cfg_data_d = '0;
            endcase
        end

        if (ctrl_wr & (cfg_data_i[1] | start)) done_d = 1'b0;
        if (abort_set) abort_d = 1'b1;
`ifdef LCD_FILL_IRQ_EN
        if (ctrl_wr) irq_en_d = cfg_data_i[3];
`endif
        if (wr & ~is_busy & (cfg_addr == 4'h4)) begin
            if (cfg_wstrb[0]) x0_d = cfg_data_i[5:0];
            if (cfg_wstrb[1]) y0_d = cfg_data_i[13:8];
            if (cfg_wstrb[2]) w_d  = cfg_data_i[21:16];
            if (cfg_wstrb[3]) h_d  = cfg_data_i[29:24];
        end
        if (wr & ~is_busy & (cfg_addr == 4'h8) & cfg_wstrb[0]) value_d = cfg_data_i[7:0];

        xsum  = {1'b0, x0_q} + {1'b0, w_q};
        ysum  = {1'b0, y0_q} + {1'b0, h_q};
        x_inc = {1'b0, x_q} + 7'd1;
        y_inc = {1'b0, y_q} + 7'd1;

        case (state_q)
            S_IDLE: if (start) state_d = S_SETUP;
            S_SETUP: begin
                xe_d = (xsum > COLS7) ? COLS7 : xsum;
                ye_d = (ysum > ROWS7) ? ROWS7 : ysum;
                if ((w_q == 6'd0) || (h_q == 6'd0) || ({1'b0, x0_q} >= COLS7) ||
                    ({1'b0, y0_q} >= ROWS7) || abort_q || abort_set) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    x_d         = x0_q;
                    y_d         = y0_q;
                    offset_d    = 12'({6'b0, y0_q}) * COLS12 + 12'({6'b0, x0_q});
                    enter_write = 1'b1;
                end
            end
            S_WRITE: if (mem_ready) begin
                state_d   = S_NEXT;
                mem_sel_d = 1'b0;
            end
            S_NEXT: begin
                // Row wrap jumps from the last column of this row to x0 of the next row.
                if (x_inc == xe_d) begin
                    x_d      = x0_q;
                    y_d      = y_q + 6'd1;
                    offset_d = offset_q + COLS12 - 12'(xe_q - {1'b0, x0_q}) + 12'd1;
                end else begin
                    x_d      = x_q + 6'd1;
                    offset_d = offset_q + 12'd1;
                end
                if (((x_inc == xe_q) && (y_inc == ye_q)) || abort_q || abort_set) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    enter_write = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_write) begin
            state_d     = S_WRITE;
            mem_sel_d   = 1'b1;
            mem_addr_d  = offset_d;
            mem_wstrb_d = 4'b0001 << offset_d[1:0];
            mem_data_d  = {4{value_q}};
        end
        if (state_d == S_IDLE && is_busy) abort_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cfg_ready_q <= 1'b0;
            cfg_data_q  <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            irq_en_q    <= 1'b0;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            value_q     <= '0;
            xe_q        <= '0;
            ye_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            offset_q    <= '0;
            mem_sel_q   <= 1'b0;
            mem_wstrb_q <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_data_q  <= cfg_data_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            irq_en_q    <= irq_en_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            w_q         <= w_d;
            h_q         <= h_d;
            value_q     <= value_d;
            xe_q        <= xe_d;
            ye_q        <= ye_d;
            x_q         <= x_d;
            y_q         <= y_d;
            offset_q    <= offset_d;
            mem_sel_q   <= mem_sel_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign cfg_data_o = cfg_data_q;
    assign mem_select = mem_sel_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign busy       = (state_q != S_IDLE);
`ifdef LCD_FILL_IRQ_EN
    assign irq        = done_q & irq_en_q;
`endif

endmodule

// File: tb/tb_lcd_tile_fill_engine.sv
// Bench for lcd_tile_fill_engine: directed and randomized fills against a rectangle-clipping model.
module tb_lcd_tile_fill_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_select;
    logic [3:0]  cfg_wstrb;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data_i;
    logic        cfg_ready;
    logic [31:0] cfg_data_o;
    logic        mem_select;
    logic [3:0]  mem_wstrb;
    logic [11:0] mem_addr;
    logic [31:0] mem_data_o;
    logic        mem_ready;
    logic        busy;
`ifdef LCD_FILL_IRQ_EN
    logic        irq;
`endif

    lcd_tile_fill_engine #(.MAP_COLS(60), .MAP_ROWS(34)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_select(cfg_select), .cfg_wstrb(cfg_wstrb), .cfg_addr(cfg_addr),
        .cfg_data_i(cfg_data_i), .cfg_ready(cfg_ready), .cfg_data_o(cfg_data_o),
        .mem_select(mem_select), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_data_o(mem_data_o), .mem_ready(mem_ready),
`ifdef LCD_FILL_IRQ_EN
        .irq(irq),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } wr_t;

    wr_t got_q[$];
    int  checks = 0;
    int  failures = 0;
    int  sink_lat = 1;
    int  sel_cycles = 0;
    int  stab_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sink: raises ready after sink_lat cycles of seeing a request, one cycle per write.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_select && !mem_ready) begin
                cnt++;
                mem_ready = (cnt > sink_lat);
            end else begin
                cnt = 0;
                mem_ready = 1'b0;
            end
        end
    end

    // Monitor: logs accepted writes, flags unstable requests and missing idle gaps.
    initial begin
        logic        p_sel, p_hs;
        logic [11:0] p_a;
        logic [3:0]  p_s;
        logic [31:0] p_d;
        p_sel = 1'b0; p_hs = 1'b0; p_a = '0; p_s = '0; p_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_sel = 1'b0;
                p_hs  = 1'b0;
            end else begin
                if (mem_select) sel_cycles++;
                if (p_hs && mem_select) stab_err++;
                if (p_sel && !p_hs && mem_select &&
                    (mem_addr !== p_a || mem_wstrb !== p_s || mem_data_o !== p_d)) stab_err++;
                if (mem_select && mem_ready) got_q.push_back('{mem_addr, mem_wstrb, mem_data_o});
                p_sel = mem_select;
                p_hs  = mem_select && mem_ready;
                p_a   = mem_addr;
                p_s   = mem_wstrb;
                p_d   = mem_data_o;
            end
        end
    end

    task automatic cfg_access(input logic [3:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [31:0] rdata);
        bit ok;
        ok = 1'b0;
        rdata = '0;
        cfg_select = 1'b1;
        cfg_addr   = addr;
        cfg_data_i = data;
        cfg_wstrb  = strb;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (cfg_ready) begin
                ok = 1'b1;
                rdata = cfg_data_o;
                break;
            end
        end
        if (!ok) chk("cfg_ack_timeout", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1;
        cfg_select = 1'b0;
        cfg_wstrb  = 4'h0;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
        logic [31:0] unused_rd;
        cfg_access(addr, data, 4'hF, unused_rd);
    endtask

    task automatic cfg_read(input logic [3:0] addr, output logic [31:0] rdata);
        cfg_access(addr, 32'h0, 4'h0, rdata);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 5000; i++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        if (busy) chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] rect_word(input int x0, input int y0, input int w, input int h);
        logic [5:0] bx, by, bw, bh;
        bx = 6'(x0); by = 6'(y0); bw = 6'(w); bh = 6'(h);
        return {2'b0, bh, 2'b0, bw, 2'b0, by, 2'b0, bx};
    endfunction

    task automatic run_fill(input string tag, input int x0, input int y0, input int w,
                            input int h, input logic [7:0] val, input int lat);
        wr_t         exp_q[$];
        int          xe, ye, n;
        logic [11:0] a;
        logic [31:0] rd;
        xe = (x0 + w > 60) ? 60 : x0 + w;
        ye = (y0 + h > 34) ? 34 : y0 + h;
        for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++) begin
                a = 12'(y * 60 + x);
                exp_q.push_back('{a, 4'(1 << (a % 4)), {4{val}}});
            end
        sink_lat = lat;
        cfg_write(4'h4, rect_word(x0, y0, w, h));
        cfg_write(4'h8, {24'h0, val});
        got_q.delete();
        sel_cycles = 0;
        stab_err = 0;
        cfg_write(4'h0, 32'h1);
        wait_idle(tag);
        chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(got_q[i].a), 32'(exp_q[i].a));
            chk($sformatf("%s_strb%0d", tag, i), 32'(got_q[i].s), 32'(exp_q[i].s));
            chk($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_q[i].d);
        end
        chk($sformatf("%s_sel_cycles", tag), sel_cycles, exp_q.size() * (lat + 1));
        chk($sformatf("%s_stability", tag), stab_err, 0);
        cfg_read(4'h0, rd);
        chk($sformatf("%s_ctrl", tag), rd, 32'h2);
    endtask

    initial begin
        logic [31:0] rd;
        int          t1_addr[6];
        int          x0, y0, w, h, lat;
        logic [7:0]  val;
        t1_addr = '{62, 63, 64, 122, 123, 124};
        rst_n = 1'b0;
        cfg_select = 1'b0;
        cfg_wstrb = 4'h0;
        cfg_addr = 4'h0;
        cfg_data_i = '0;
        #1;
        chk("rst_mem_select", 32'(mem_select), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", mem_data_o, 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_cfg_data", cfg_data_o, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cfg_read(4'h0, rd);
        chk("rst_ctrl", rd, 32'h0);

        run_fill("t1", 2, 1, 3, 2, 8'h05, 1);
        for (int i = 0; i < 6; i++)
            if (i < got_q.size()) chk($sformatf("t1_fixed_addr%0d", i), 32'(got_q[i].a), t1_addr[i]);
        cfg_read(4'h4, rd);
        chk("rect_readback", rd, 32'h02030102);
        cfg_read(4'h8, rd);
        chk("value_readback", rd, 32'h05);

        run_fill("t2_clip", 58, 33, 10, 5, 8'hA7, 1);

        cfg_write(4'h0, 32'h2);
        cfg_read(4'h0, rd);
        chk("clear_done", rd, 32'h0);
        cfg_write(4'h4, rect_word(5, 5, 0, 3));
        sel_cycles = 0;
        cfg_write(4'h0, 32'h1);
        chk("t3_setup_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("t3_idle_next", 32'(busy), 32'd0);
        cfg_read(4'h0, rd);
        chk("t3_ctrl", rd, 32'h2);
        chk("t3_no_select", sel_cycles, 0);
        run_fill("t3_x60", 60, 2, 4, 2, 8'h11, 1);
        run_fill("t3_h0", 3, 3, 4, 0, 8'h22, 1);

        run_fill("t4_slow", 10, 20, 3, 2, 8'h3C, 4);

        // Start and abort together in idle: nothing starts.
        cfg_write(4'h0, 32'h2);
        cfg_write(4'h4, rect_word(0, 0, 4, 1));
        sel_cycles = 0;
        cfg_write(4'h0, 32'h5);
        repeat (4) @(posedge clk);
        #1;
        cfg_read(4'h0, rd);
        chk("start_abort_ctrl", rd, 32'h0);
        chk("start_abort_nosel", sel_cycles, 0);

        // Abort during the 3rd write of a 20-tile fill.
        sink_lat = 4;
        cfg_write(4'h4, rect_word(0, 4, 20, 1));
        cfg_write(4'h8, 32'h77);
        got_q.delete();
        cfg_write(4'h0, 32'h1);
        cfg_write(4'h4, 32'h3F3F3F3F);
        for (int i = 0; i < 200; i++) begin
            if (mem_select && got_q.size() == 2) break;
            @(posedge clk);
            #1;
        end
        chk("t5_reached_third", got_q.size(), 2);
        cfg_write(4'h0, 32'h4);
        cfg_read(4'h0, rd);
        chk("t5_pending", rd, 32'h5);
        wait_idle("t5");
        chk("t5_count", got_q.size(), 3);
        if (got_q.size() == 3) chk("t5_last_addr", 32'(got_q[2].a), 32'd242);
        cfg_read(4'h0, rd);
        chk("t5_ctrl", rd, 32'h2);
        cfg_read(4'h4, rd);
        chk("t5_rect_locked", rd, rect_word(0, 4, 20, 1));

        // Reset mid-write.
        cfg_write(4'h0, 32'h1);
        for (int i = 0; i < 50; i++) begin
            if (mem_select) break;
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_sel_async", 32'(mem_select), 32'd0);
        chk("t6_busy_async", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cfg_read(4'h0, rd);
        chk("t6_ctrl", rd, 32'h0);
        cfg_read(4'h4, rd);
        chk("t6_rect", rd, 32'h0);
        run_fill("t6_restart", 1, 1, 2, 2, 8'h99, 1);

`ifdef LCD_FILL_IRQ_EN
        cfg_write(4'h0, 32'hA);
        chk("irq_low", 32'(irq), 32'd0);
        run_fill("irq_fill", 0, 0, 1, 1, 8'h01, 1);
        cfg_write(4'h0, 32'h8);
        chk("irq_high", 32'(irq), 32'd1);
`endif

        for (int k = 0; k < 10; k++) begin
            x0  = $urandom_range(0, 63);
            y0  = $urandom_range(0, 63);
            w   = $urandom_range(0, 12);
            h   = $urandom_range(0, 6);
            if (k % 3 == 0) begin
                x0 = $urandom_range(50, 59);
                y0 = $urandom_range(28, 33);
            end
            val = 8'($urandom);
            lat = $urandom_range(1, 3);
            run_fill($sformatf("rnd%0d", k), x0, y0, w, h, val, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
